// File: rtl/pkt_buf_pkg.sv
// Shared definitions for the store-and-forward packet buffer.
package pkt_buf_pkg;

  localparam int unsigned PKT_BUF_DEPTH = 64;
  localparam int unsigned PKT_BUF_DW    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_PKT = 2'd1,
    DROP   = 2'd2
  } wr_state_e;

endpackage : pkt_buf_pkg

// File: rtl/pkt_buf_ram.sv
// Packet store: flop array with one synchronous write port and one async read port.
module pkt_buf_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : pkt_buf_ram

// File: rtl/pkt_sf_buffer.sv
// Store-and-forward packet buffer: bytes become readable only once their packet's eop is written;
// incomplete or oversize packets are rolled back to the last commit point and counted as drops.
module pkt_sf_buffer
  import pkt_buf_pkg::*;
#(
  parameter int unsigned DEPTH = PKT_BUF_DEPTH,
  parameter int unsigned DW    = PKT_BUF_DW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   w_valid,
  input  logic [DW-1:0]          w_data,
  input  logic                   w_sop,
  input  logic                   w_eop,
  output logic                   w_ready,
  output logic                   r_valid,
  output logic [DW-1:0]          r_data,
  output logic                   r_sop,
  output logic                   r_eop,
  input  logic                   r_ready,
  output logic [$clog2(DEPTH):0] pkt_count,
  output logic [15:0]            drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = DW + 1;

  wr_state_e       r_state;
  wr_state_e       w_state_nxt;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_cm_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_pkt_cnt;
  logic [15:0]     r_drop_cnt;
  logic            r_first;

  logic [PW-1:0]   w_occ;
  logic            w_full;
  logic            w_stall;
  logic            w_wr_fire;
  logic            w_rd_fire;
  logic            w_we;
  logic            w_rollback;
  logic            w_commit;
  logic            w_drop;
  logic [PW-1:0]   w_waddr;
  logic [EW-1:0]   w_rd_entry;
  logic            w_rd_eop_fire;

  // Occupancy includes the uncommitted tail of the packet being written
  assign w_occ     = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_occ == PW'(DEPTH));
  assign w_stall   = w_full && (r_pkt_cnt != '0);
  assign w_ready   = ((r_state == IN_PKT) || w_sop) ? !w_stall : 1'b1;
  assign w_wr_fire = w_valid && w_ready;
  assign w_waddr   = w_rollback ? r_cm_ptr : r_wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_rollback  = 1'b0;
    w_commit    = 1'b0;
    w_drop      = 1'b0;
    if (w_wr_fire) begin
      case (r_state)
        IDLE, DROP: begin
          if (w_sop) begin
            w_we        = 1'b1;
            w_commit    = w_eop;
            w_state_nxt = w_eop ? IDLE : IN_PKT;
          end else if (w_eop) begin
            w_state_nxt = IDLE;
          end
        end
        IN_PKT: begin
          if (w_sop) begin
            w_rollback  = 1'b1;
            w_drop      = 1'b1;
            w_we        = 1'b1;
            w_commit    = w_eop;
            w_state_nxt = w_eop ? IDLE : IN_PKT;
          end else if (w_full) begin
            // Oversize packet: nothing committed can drain, so abandon it
            w_rollback  = 1'b1;
            w_drop      = 1'b1;
            w_state_nxt = w_eop ? IDLE : DROP;
          end else begin
            w_we        = 1'b1;
            w_commit    = w_eop;
            w_state_nxt = w_eop ? IDLE : IN_PKT;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_rd_fire     = r_valid && r_ready;
  assign w_rd_eop_fire = w_rd_fire && w_rd_entry[DW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_cm_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
      r_first    <= 1'b1;
    end else begin
      if (w_we) begin
        r_wr_ptr <= w_waddr + PW'(1);
      end else if (w_rollback) begin
        r_wr_ptr <= r_cm_ptr;
      end
      if (w_commit) begin
        r_cm_ptr <= w_waddr + PW'(1);
      end
      if (w_rd_fire) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_first  <= w_rd_entry[DW];
      end
      case ({w_commit, w_rd_eop_fire})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + PW'(1);
        2'b01:   r_pkt_cnt <= r_pkt_cnt - PW'(1);
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  pkt_buf_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr[AW-1:0]),
    .i_wdata ({w_eop, w_data}),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rd_entry)
  );

  // Read side presents the head entry directly; sop is rebuilt from the previous eop
  assign r_valid    = (r_pkt_cnt != '0);
  assign r_data     = r_valid ? w_rd_entry[DW-1:0] : '0;
  assign r_eop      = r_valid && w_rd_entry[DW];
  assign r_sop      = r_valid && r_first;
  assign pkt_count  = r_pkt_cnt;
  assign drop_count = r_drop_cnt;

endmodule : pkt_sf_buffer

// File: tb/tb_pkt_sf_buffer.sv
// Scoreboard bench for pkt_sf_buffer: stimulus pushes expected read beats, a monitor pops and compares.
module tb_pkt_sf_buffer;

  logic        clk;
  logic        rst_n;
  logic        w_valid;
  logic [7:0]  w_data;
  logic        w_sop;
  logic        w_eop;
  logic        w_ready;
  logic        r_valid;
  logic [7:0]  r_data;
  logic        r_sop;
  logic        r_eop;
  logic        r_ready;
  logic [6:0]  pkt_count;
  logic [15:0] drop_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0]  exp_q[$];
  logic        p_hold;
  logic [10:0] p_val;

  pkt_sf_buffer #(.DEPTH(64), .DW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .w_valid    (w_valid),
    .w_data     (w_data),
    .w_sop      (w_sop),
    .w_eop      (w_eop),
    .w_ready    (w_ready),
    .r_valid    (r_valid),
    .r_data     (r_data),
    .r_sop      (r_sop),
    .r_eop      (r_eop),
    .r_ready    (r_ready),
    .pkt_count  (pkt_count),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Read-side monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (p_hold) check("hold_stable", 32'({r_valid, r_sop, r_eop, r_data}), 32'(p_val));
      if (r_valid && r_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got sop=%0b eop=%0b data=0x%0h expected none at %0t",
                   r_sop, r_eop, r_data, $time);
        end else begin
          check("rd_beat", 32'({r_sop, r_eop, r_data}), 32'(exp_q.pop_front()));
        end
      end
    end
    p_hold = rst_n && r_valid && !r_ready;
    p_val  = {r_valid, r_sop, r_eop, r_data};
  end

  task automatic put(input logic [7:0] d, input logic s, input logic e);
    int n;
    w_valid = 1'b1;
    w_data  = d;
    w_sop   = s;
    w_eop   = e;
    n = 0;
    forever begin
      @(negedge clk);
      if (w_ready) break;
      n++;
      if (n > 1000) begin
        n_tests++;
        n_fail++;
        $display("FAIL put_timeout: got w_ready=0 for %0d cycles expected 1", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    w_valid = 1'b0;
    w_sop   = 1'b0;
    w_eop   = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] base, input int len, input bit expect_out);
    for (int i = 0; i < len; i++) begin
      if (expect_out) exp_q.push_back({(i == 0), (i == len - 1), 8'(base + 8'(i))});
      put(8'(base + 8'(i)), (i == 0), (i == len - 1));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || r_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    w_valid = 1'b0;
    w_data  = '0;
    w_sop   = 1'b0;
    w_eop   = 1'b0;
    r_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_r_valid", 32'(r_valid), 32'd0);
    check("rst_r_sop", 32'(r_sop), 32'd0);
    check("rst_r_eop", 32'(r_eop), 32'd0);
    check("rst_pkt_count", 32'(pkt_count), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_w_ready", 32'(w_ready), 32'd1);

    // 5-byte packet, latency and sop/eop placement
    r_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({(i == 0), (i == 4), 8'(8'h10 + 8'(i))});
      if (i == 4) check("sf_no_early_valid", 32'(r_valid), 32'd0);
      put(8'(8'h10 + 8'(i)), (i == 0), (i == 4));
    end
    check("eop_latency_valid", 32'(r_valid), 32'd1);
    drain();
    check("p1_pkt_count", 32'(pkt_count), 32'd0);

    // Abandoned packet A replaced by B
    put(8'hA0, 1'b1, 1'b0);
    put(8'hA1, 1'b0, 1'b0);
    send_pkt(8'hB0, 2, 1'b1);
    drain();
    check("restart_drop_count", 32'(drop_count), 32'd1);

    // Stray beat outside a packet
    put(8'h55, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("stray_r_valid", 32'(r_valid), 32'd0);
    check("stray_drop_count", 32'(drop_count), 32'd1);
    check("stray_pkt_count", 32'(pkt_count), 32'd0);

    // Oversize 70-byte packet
    r_ready = 1'b0;
    send_pkt(8'h00, 70, 1'b0);
    check("oversize_pkt_count", 32'(pkt_count), 32'd0);
    check("oversize_drop_count", 32'(drop_count), 32'd2);
    repeat (3) @(posedge clk);
    #1;
    check("oversize_r_valid", 32'(r_valid), 32'd0);

    // Backpressure on full store with committed packets
    send_pkt(8'h20, 32, 1'b1);
    send_pkt(8'h80, 32, 1'b1);
    check("full_pkt_count", 32'(pkt_count), 32'd2);
    w_valid = 1'b1;
    w_data  = 8'hC0;
    w_sop   = 1'b1;
    w_eop   = 1'b0;
    repeat (3) @(negedge clk);
    check("full_w_ready", 32'(w_ready), 32'd0);
    @(posedge clk);
    #1;
    r_ready = 1'b1;
    send_pkt(8'hC0, 8, 1'b1);
    drain();
    check("full_after_pkt_count", 32'(pkt_count), 32'd0);
    check("full_after_drop_count", 32'(drop_count), 32'd2);

    // Reset mid-read and mid-packet
    r_ready = 1'b0;
    send_pkt(8'hD0, 4, 1'b1);
    put(8'hE0, 1'b1, 1'b0);
    put(8'hE1, 1'b0, 1'b0);
    r_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_r_valid", 32'(r_valid), 32'd0);
    check("mid_rst_r_sop", 32'(r_sop), 32'd0);
    check("mid_rst_r_eop", 32'(r_eop), 32'd0);
    check("mid_rst_r_data", 32'(r_data), 32'd0);
    check("mid_rst_pkt_count", 32'(pkt_count), 32'd0);
    check("mid_rst_drop_count", 32'(drop_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_w_ready", 32'(w_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_no_beat", 32'(r_valid), 32'd0);
    exp_q.push_back({1'b1, 1'b1, 8'h7E});
    put(8'h7E, 1'b1, 1'b1);
    check("one_byte_r_valid", 32'(r_valid), 32'd1);
    check("one_byte_sop_eop", 32'({r_sop, r_eop}), 32'd3);
    drain();
    check("one_byte_pkt_count", 32'(pkt_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pkt_sf_buffer
